// File: rtl/pipe_ctrl_gen.sv
// Pipeline control for the MIPS core: stall vector generation, exception flush/redirect
// with a configurable hold length, and a stall watchdog that flags livelock.
module pipe_ctrl_gen #(
    parameter int          NSTAGE    = 6,
    parameter logic [31:0] EBASE     = 32'h80000180,
    parameter logic [31:0] BOOT_BASE = 32'hBFC00380,
    parameter int          FLUSH_LEN = 1,
    parameter int          WDT_LIMIT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stallreq_i,
    input  logic [31:0]       excepttype_i,
    input  logic [31:0]       cp0_epc_i,
    input  logic              cp0_bev_i,
    output logic [NSTAGE-1:0] stall,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              wdt_fault_o
);

    localparam int          FW        = $clog2(FLUSH_LEN + 1);
    localparam int          WW        = (WDT_LIMIT > 0) ? $clog2(WDT_LIMIT + 1) : 1;
    localparam logic [31:0] ERET_CODE = 32'h0000000e;

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t            state_q, state_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;
    logic [WW-1:0]     wcnt_q, wcnt_d;
    logic [31:0]       pc_hold_q, pc_hold_d;
    logic              wdt_fault_q, wdt_fault_d;

    logic [NSTAGE-1:0] stall_vec;
    logic              stall_acc;
    logic              except_take;
    logic [31:0]       vector_pc;
    logic [WW-1:0]     wcnt_inc;
    logic              unused_stallreq0;

    assign unused_stallreq0 = stallreq_i[0];

    // A request from stage k freezes stage k and everything upstream of it, PC included.
    always_comb begin
        stall_vec = '0;
        stall_acc = 1'b0;
        for (int k = NSTAGE - 1; k >= 1; k--) begin
            stall_acc    = stall_acc | stallreq_i[k];
            stall_vec[k] = stall_acc;
        end
        stall_vec[0] = stall_acc;
    end

    always_comb begin
        except_take = (state_q == ST_RUN) && (excepttype_i != '0);
        if (excepttype_i == ERET_CODE) begin
            vector_pc = cp0_epc_i;
        end else begin
            vector_pc = cp0_bev_i ? BOOT_BASE : EBASE;
        end
    end

    always_comb begin
        stall  = '0;
        flush  = 1'b0;
        new_pc = '0;
        if (!rst) begin
            if (state_q == ST_FLUSH) begin
                flush  = 1'b1;
                new_pc = pc_hold_q;
            end else if (except_take) begin
                flush  = 1'b1;
                new_pc = vector_pc;
            end else begin
                stall = stall_vec;
            end
        end
    end

    // Watchdog only advances on stalled RUN cycles; every other cycle clears it.
    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        pc_hold_d   = pc_hold_q;
        wcnt_d      = '0;
        wdt_fault_d = 1'b0;
        wcnt_inc    = wcnt_q + WW'(1);
        case (state_q)
            ST_FLUSH: begin
                if (fcnt_q <= FW'(1)) begin
                    state_d = ST_RUN;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q - FW'(1);
                end
            end
            default: begin
                if (except_take) begin
                    pc_hold_d = vector_pc;
                    if (FLUSH_LEN > 1) begin
                        state_d = ST_FLUSH;
                        fcnt_d  = FW'(FLUSH_LEN - 1);
                    end
                end else if ((stall_vec != '0) && (WDT_LIMIT != 0)) begin
                    if (wcnt_inc == WW'(WDT_LIMIT)) begin
                        wdt_fault_d = 1'b1;
                    end else begin
                        wcnt_d = wcnt_inc;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            fcnt_q      <= '0;
            wcnt_q      <= '0;
            pc_hold_q   <= '0;
            wdt_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            wcnt_q      <= wcnt_d;
            pc_hold_q   <= pc_hold_d;
            wdt_fault_q <= wdt_fault_d;
        end
    end

    assign wdt_fault_o = wdt_fault_q;

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Scoreboard bench for pipe_ctrl_gen: three instances (flush lengths 1/3/4, watchdog 4/4/off)
// share one stimulus stream and are checked against a behavioural model every cycle.
module tb_pipe_ctrl_gen;

    localparam int N  = 6;
    localparam int NI = 3;
    localparam logic [31:0] EBASE_V = 32'h80000180;
    localparam logic [31:0] BOOT_V  = 32'hBFC00380;

    typedef struct {
        logic [N-1:0] stall;
        logic         flush;
        logic [31:0]  new_pc;
        logic         wdt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] stallreq = '0;
    logic [31:0]  exc = '0;
    logic [31:0]  epc = '0;
    logic         bev = 1'b0;

    logic [N-1:0] stall_o [NI];
    logic         flush_o [NI];
    logic [31:0]  pc_o    [NI];
    logic         wdt_o   [NI];

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Behavioural model state per instance
    int          flen [NI];
    int          wlim [NI];
    int          fleft [NI];
    logic [31:0] hold [NI];
    int          stall_run [NI];
    bit          fault [NI];

    exp_t sb [NI][$];

    always #5 clk = ~clk;

    pipe_ctrl_gen #(.NSTAGE(N), .EBASE(EBASE_V), .BOOT_BASE(BOOT_V), .FLUSH_LEN(1), .WDT_LIMIT(4)) dut_a (
        .clk(clk), .rst(rst), .stallreq_i(stallreq), .excepttype_i(exc), .cp0_epc_i(epc), .cp0_bev_i(bev),
        .stall(stall_o[0]), .flush(flush_o[0]), .new_pc(pc_o[0]), .wdt_fault_o(wdt_o[0]));

    pipe_ctrl_gen #(.NSTAGE(N), .EBASE(EBASE_V), .BOOT_BASE(BOOT_V), .FLUSH_LEN(3), .WDT_LIMIT(4)) dut_b (
        .clk(clk), .rst(rst), .stallreq_i(stallreq), .excepttype_i(exc), .cp0_epc_i(epc), .cp0_bev_i(bev),
        .stall(stall_o[1]), .flush(flush_o[1]), .new_pc(pc_o[1]), .wdt_fault_o(wdt_o[1]));

    pipe_ctrl_gen #(.NSTAGE(N), .EBASE(EBASE_V), .BOOT_BASE(BOOT_V), .FLUSH_LEN(4), .WDT_LIMIT(0)) dut_c (
        .clk(clk), .rst(rst), .stallreq_i(stallreq), .excepttype_i(exc), .cp0_epc_i(epc), .cp0_bev_i(bev),
        .stall(stall_o[2]), .flush(flush_o[2]), .new_pc(pc_o[2]), .wdt_fault_o(wdt_o[2]));

    // Reference model: expected outputs for the current cycle, then advance to the next cycle.
    task automatic model_step(input int i, input logic r, input logic [N-1:0] sreq,
                              input logic [31:0] ex, input logic [31:0] ep, input logic b,
                              output exp_t e);
        int s;
        e.stall  = '0;
        e.flush  = 1'b0;
        e.new_pc = '0;
        e.wdt    = 1'b0;
        if (r) begin
            fleft[i]     = 0;
            hold[i]      = '0;
            stall_run[i] = 0;
            fault[i]     = 1'b0;
            return;
        end
        e.wdt    = fault[i];
        fault[i] = 1'b0;
        if (fleft[i] > 0) begin
            e.flush      = 1'b1;
            e.new_pc     = hold[i];
            fleft[i]     = fleft[i] - 1;
            stall_run[i] = 0;
        end else if (ex != 0) begin
            e.flush      = 1'b1;
            e.new_pc     = (ex == 32'he) ? ep : (b ? BOOT_V : EBASE_V);
            hold[i]      = e.new_pc;
            fleft[i]     = flen[i] - 1;
            stall_run[i] = 0;
        end else begin
            s = 0;
            for (int k = N - 1; k >= 1; k--) begin
                if (sreq[k]) begin
                    s = k;
                    break;
                end
            end
            if (s > 0) begin
                e.stall = N'((1 << (s + 1)) - 1);
                stall_run[i] = stall_run[i] + 1;
                if (wlim[i] > 0 && stall_run[i] == wlim[i]) begin
                    fault[i]     = 1'b1;
                    stall_run[i] = 0;
                end
            end else begin
                stall_run[i] = 0;
            end
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and queue what every instance should show.
    task automatic applyStimulus(input logic r, input logic [N-1:0] sreq, input logic [31:0] ex,
                                 input logic [31:0] ep, input logic b);
        exp_t e;
        @(posedge clk);
        #1;
        rst      = r;
        stallreq = sreq;
        exc      = ex;
        epc      = ep;
        bev      = b;
        for (int i = 0; i < NI; i++) begin
            model_step(i, r, sreq, ex, ep, b, e);
            sb[i].push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input int inst, input logic [31:0] act,
                               input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s inst=%0d cycle=%0d: got %h, expected %h", name, inst, cycle, act, expv);
        end
    endtask

    // Monitor: outputs are presented every cycle, so pop one expectation per instance per falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cycle++;
            for (int i = 0; i < NI; i++) begin
                if (sb[i].size() > 0) begin
                    e = sb[i].pop_front();
                    checkOutput("stall",  i, 32'(stall_o[i]), 32'(e.stall));
                    checkOutput("flush",  i, 32'(flush_o[i]), 32'(e.flush));
                    checkOutput("new_pc", i, pc_o[i], e.new_pc);
                    checkOutput("wdt",    i, 32'(wdt_o[i]), 32'(e.wdt));
                end
            end
        end
    end

    initial begin
        logic [31:0] rex;
        flen = '{1, 3, 4};
        wlim = '{4, 4, 0};
        for (int i = 0; i < NI; i++) begin
            fleft[i] = 0; hold[i] = '0; stall_run[i] = 0; fault[i] = 1'b0;
        end

        // Reset with garbage inputs, then release into idle
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, N'($urandom), 32'h8, $urandom, 1'($urandom));
        idle(2);

        // Stall decode
        applyStimulus(1'b0, 6'b000100, '0, '0, 1'b0);
        applyStimulus(1'b0, 6'b011000, '0, '0, 1'b0);
        applyStimulus(1'b0, 6'b000001, '0, '0, 1'b0);
        idle(1);

        // Exception vectors
        applyStimulus(1'b0, '0, 32'h8, 32'h12345678, 1'b0);
        idle(4);
        applyStimulus(1'b0, '0, 32'h8, 32'h12345678, 1'b1);
        idle(4);
        applyStimulus(1'b0, '0, 32'he, 32'h80001234, 1'b0);
        idle(4);

        // Held flush ignores a second exception and a changed EPC
        applyStimulus(1'b0, 6'b011000, 32'h4, 32'h80000010, 1'b0);
        applyStimulus(1'b0, 6'b011000, 32'he, 32'h80009999, 1'b1);
        applyStimulus(1'b0, 6'b011000, 32'h0, 32'h80009999, 1'b1);
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        idle(2);

        // Exception on the last held cycle is dropped, the following one is taken
        applyStimulus(1'b0, '0, 32'h8, '0, 1'b0);
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        applyStimulus(1'b0, '0, 32'he, 32'h80004000, 1'b0);
        applyStimulus(1'b0, '0, 32'he, 32'h80005000, 1'b0);
        idle(4);

        // Watchdog: sustained stall, a one-cycle gap, then a second run
        for (int k = 0; k < 12; k++) applyStimulus(1'b0, 6'b001000, '0, '0, 1'b0);
        idle(1);
        for (int k = 0; k < 6; k++) applyStimulus(1'b0, 6'b001000, '0, '0, 1'b0);
        idle(2);

        // Reset on the second flush cycle
        applyStimulus(1'b0, '0, 32'h8, '0, 1'b1);
        applyStimulus(1'b1, '0, 32'h8, '0, 1'b1);
        idle(4);

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 3))
                0:       rex = 32'h8;
                1:       rex = 32'he;
                2:       rex = 32'h4;
                default: rex = $urandom | 32'h1;
            endcase
            if ($urandom_range(0, 7) != 0) rex = '0;
            applyStimulus(($urandom_range(0, 49) == 0), N'($urandom), rex, $urandom, 1'($urandom));
        end
        idle(2);

        begin
            int waited = 0;
            while ((sb[0].size() + sb[1].size() + sb[2].size()) > 0 && waited < 20) begin
                @(posedge clk);
                waited++;
            end
            if ((sb[0].size() + sb[1].size() + sb[2].size()) > 0) begin
                errors++;
                $display("[TB] FAIL drain: %0d expectations left, expected 0",
                         sb[0].size() + sb[1].size() + sb[2].size());
            end
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_gen.md
# pipe_ctrl_gen

Parametrised pipeline control unit for the MIPS core, replacing the fixed six-stage stall/flush decoder. It converts per-stage stall requests into a generalised stall vector, turns a committed exception or eret from the memory stage into a flush plus redirect PC, and holds flush for a configurable number of cycles. It also runs a stall watchdog that reports pipeline livelock. It sits between the stage stall-request outputs, the MEM/CP0 exception path, and the PC/pipeline-register stall and flush inputs.

## Interface
- NSTAGE, 6: pipeline register count. Bit 0 is PC, 1 is IF, 2 is ID, 3 is EX, 4 is MEM, 5 is WB.
- EBASE, 32'h80000180: general exception vector when BEV=0.
- BOOT_BASE, 32'hBFC00380: exception vector when BEV=1.
- FLUSH_LEN, 1: cycles flush stays asserted per accepted exception (≥1).
- WDT_LIMIT, 1024: consecutive stalled cycles before a watchdog fault. 0 disables the watchdog.
- clk  in  1  clock. Everything is rising-edge.
- rst  in  1  asynchronous reset, active-high (`RstEnable`).
- stallreq_i  in  NSTAGE  per-stage stall request (`Stop` = 1). Bit 0 is ignored.
- excepttype_i  in  32  exception code from MEM. `ZeroWord` means none.
- cp0_epc_i  in  32  EPC from CP0.
- cp0_bev_i  in  1  CP0 Status.BEV.
- stall  out  NSTAGE  stall vector.
- flush  out  1  pipeline flush.
- new_pc  out  32  redirect PC. Valid while flush=1, otherwise `ZeroWord`.
- wdt_fault_o  out  1  one-cycle watchdog pulse.

## Operation
- **States:**
  - RUN: normal operation.
  - FLUSH: holds the flush; a down-counter `fcnt` (width clog2(FLUSH_LEN+1)) tracks remaining cycles.
- **Priority:** reset > FLUSH hold > new exception > stall requests.
- **RUN with excepttype_i ≠ 0:**
  - flush=1 and stall=0 in the same cycle (combinational).
  - new_pc decoded:
    - 32'h0000000e (eret) → cp0_epc_i.
    - Any other nonzero code (including unlisted codes) → (cp0_bev_i ? BOOT_BASE : EBASE).
  - new_pc is latched into `pc_hold`.
  - If FLUSH_LEN>1: go to FLUSH with fcnt=FLUSH_LEN-1. Otherwise stay in RUN.
- **FLUSH:**
  - flush=1, stall=0, new_pc=pc_hold.
  - excepttype_i and stallreq_i are ignored.
  - fcnt decrements each cycle. Return to RUN on the cycle fcnt reaches 1 (the last held cycle).
- **Stall in RUN, no exception:**
  - s = index of the highest set bit of stallreq_i[NSTAGE-1:1].
  - stall[k]=1 for k≤s, 0 above. Example for NSTAGE=6: MEM request → 6'b011111.
  - No request → stall=0.
- **Watchdog (`wcnt`, width clog2(WDT_LIMIT+1)):**
  - Increments each RUN cycle with stall≠0.
  - Clears on any cycle with stall=0, with flush=1, or in FLUSH.
  - When wcnt reaches WDT_LIMIT: next cycle wdt_fault_o=1 for exactly one cycle and wcnt=0. Counting resumes if the stall persists, so the fault repeats every WDT_LIMIT stalled cycles.
  - The watchdog has no effect on stall or flush.
- **Reset (asynchronous, any state):** state=RUN, fcnt=0, wcnt=0, pc_hold=0, wdt_fault_o=0. Combinational outputs follow to stall=0, flush=0, new_pc=0 while rst=1.

## Timing
- Exception to flush/new_pc: 0 cycles (combinational).
- Flush duration: exactly FLUSH_LEN cycles per accepted exception.
- Stall request to stall vector: 0 cycles.
- An exception arriving on the last FLUSH cycle is ignored. One arriving the cycle after FLUSH ends is accepted.
- Exception and stall requests in the same cycle: the exception wins; the stall is dropped and wcnt cleared.
- cp0_epc_i and cp0_bev_i are sampled only in the acceptance cycle. Changes during FLUSH do not alter new_pc.
- Reset asserted mid-FLUSH: flush drops immediately (asynchronous). After deassertion the block is in RUN with no pending redirect.
- wdt_fault_o is registered: 1 cycle after the limit is reached.

## Test plan
- **Reset/idle:** rst=1 with random inputs → stall=0, flush=0, new_pc=0, wdt_fault_o=0. Release with all inputs 0 → outputs stay 0.
- **Stall decode (NSTAGE=6):**
  - stallreq_i=6'b000100 (ID) → stall=6'b000111.
  - 6'b011000 → 6'b011111.
  - 6'b000001 → 6'b000000.
- **Exception vectors, FLUSH_LEN=1:**
  - excepttype_i=32'h8, bev=0 → flush=1 for 1 cycle, new_pc=32'h80000180.
  - Same with bev=1 → new_pc=32'hBFC00380.
  - excepttype_i=32'he, epc=32'h80001234 → new_pc=32'h80001234.
- **FLUSH_LEN=3:**
  - Exception 32'h4 at cycle T with stallreq_i=6'b011000 → flush=1 for T..T+2, stall=0, new_pc held.
  - Second exception at T+1 and a changed epc are ignored.
  - flush=0 at T+3.
- **Watchdog, WDT_LIMIT=4:**
  - Hold stallreq_i=6'b001000 → wdt_fault_o pulses once 4 cycles after the stall began, then again 4 cycles later.
  - Dropping the stall for one cycle restarts the count.
- **Reset mid-FLUSH (FLUSH_LEN=4):** rst asserted at the second flush cycle → flush=0 immediately. After release, no residual flush and new_pc=0.
